// File: rtl/mod_periodmeter.sv
// Period meter: measures the spacing, in valid samples, between rising zero
// crossings of a signed sample stream, using hysteresis and a lock indicator.
module mod_periodmeter #(
    parameter int unsigned HYST       = 8192,
    parameter int unsigned MIN_PERIOD = 4,
    parameter int unsigned MAX_PERIOD = 1048576,
    parameter int unsigned LOCK_TOL   = 1
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [31:0] i_sample,
    input  logic        i_valid,
    output logic [31:0] o_period,
    output logic        o_period_valid,
    output logic        o_locked,
    output logic        o_dbg_run
);

    typedef enum logic {SEEK = 1'b0, RUN = 1'b1} state_t;

    localparam logic signed [31:0] POS_TH = $signed(HYST);
    localparam logic signed [31:0] NEG_TH = -$signed(HYST);

    state_t      state;
    logic        armed;
    logic [31:0] cnt;
    logic [31:0] prev;

    logic               arm_lvl;
    logic               cross_lvl;
    logic               crossing;
    logic [31:0]        cand;
    logic signed [32:0] diff;
    logic signed [32:0] mag;
    logic               within_tol;

    // Crossing detection and lock distance, evaluated against the current sample.
    always_comb begin
        arm_lvl    = $signed(i_sample) <= NEG_TH;
        cross_lvl  = $signed(i_sample) >= POS_TH;
        crossing   = armed && cross_lvl;
        cand       = cnt + 32'd1;
        diff       = $signed({1'b0, cand}) - $signed({1'b0, prev});
        mag        = (diff < 0) ? -diff : diff;
        within_tol = mag <= $signed({1'b0, LOCK_TOL});
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state          <= SEEK;
            armed          <= 1'b0;
            cnt            <= '0;
            prev           <= '0;
            o_period       <= '0;
            o_period_valid <= 1'b0;
            o_locked       <= 1'b0;
        end else begin
            o_period_valid <= 1'b0;
            if (i_valid) begin
                // A crossing always consumes the arm, even when rejected as a glitch.
                if (crossing) begin
                    armed <= 1'b0;
                end else if (arm_lvl) begin
                    armed <= 1'b1;
                end
                case (state)
                    SEEK: begin
                        cnt <= '0;
                        if (crossing) begin
                            state <= RUN;
                        end
                    end
                    RUN: begin
                        if (crossing && (cand >= MIN_PERIOD)) begin
                            o_period       <= cand;
                            o_period_valid <= 1'b1;
                            prev           <= cand;
                            cnt            <= '0;
                            if (prev != '0) begin
                                o_locked <= within_tol;
                            end
                        end else if (!crossing && (cand == MAX_PERIOD)) begin
                            state    <= SEEK;
                            cnt      <= '0;
                            armed    <= 1'b0;
                            prev     <= '0;
                            o_locked <= 1'b0;
                        end else begin
                            cnt <= cand;
                        end
                    end
                endcase
            end
        end
    end

    assign o_dbg_run = (state == RUN);

endmodule
